regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//   Sequences the single register-file write port and shares it between two writeback requesters:
//   A = ALU writeback, B = load/multicycle unit.
//   After reset it first sweeps zeros into r1..r(NUM_REGS-1). It then runs round-robin arbitration
//   with valid/ready handshakes and drives the registered write port
//   (ctrl_writeEnable, ctrl_writeReg, data_writeReg).
// PARAMETERS
//   DATA_W    32  width of write data
//   ADDR_W    5   width of register index
//   NUM_REGS  32  number of registers; r0 is hard-wired zero and never written
// PORTS
//   clock             in   1       system clock, rising edge
//   ctrl_reset_n      in   1       asynchronous, active-low reset
//   a_valid           in   1       requester A has a write pending
//   a_reg             in   ADDR_W  A destination register
//   a_data            in   DATA_W  A write data
//   a_ready           out  1       A transfer accepted this cycle
//   b_valid           in   1       requester B has a write pending
//   b_reg             in   ADDR_W  B destination register
//   b_data            in   DATA_W  B write data
//   b_ready           out  1       B transfer accepted this cycle
//   ctrl_writeEnable  out  1       register-file write enable
//   ctrl_writeReg     out  ADDR_W  register-file write index
//   data_writeReg     out  DATA_W  register-file write data
//   init_done         out  1       sweep complete, arbiter in RUN
// BEHAVIOUR
//   - Reset (async assert, sync release):
//     - state=INIT, sweep_cnt=1, rr_last=B (so A wins the first tie).
//     - ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0, init_done=0.
//     - a_ready=b_ready=0.
//   - All write-port outputs and init_done are registered. a_ready/b_ready are combinational.
//   - INIT:
//     - Each cycle register ctrl_writeEnable=1, ctrl_writeReg=sweep_cnt, data_writeReg=0, then
//       sweep_cnt++.
//     - When the write of NUM_REGS-1 is issued, go to RUN. init_done=1 from the next cycle and is
//       sticky until reset.
//     - a_ready=b_ready=0 throughout INIT.
//   - RUN arbitration:
//     - Only one valid: that requester gets ready=1.
//     - Both valid: the one not equal to rr_last gets ready=1; the other gets 0.
//     - Neither valid: both ready=0.
//     - Ready is never asserted without valid.
//   - Transfer = valid & ready.
//     - On a transfer, rr_last := granted requester.
//     - Without a transfer, rr_last holds.
//   - Latency: a transfer in cycle N produces the write outputs in cycle N+1 (ctrl_writeEnable=1,
//     reg/data of the winner). The write commits at the N+2 edge.
//   - Idle cycle: ctrl_writeEnable=0 and ctrl_writeReg/data_writeReg hold their last values.
//   - Throughput: one write per cycle. Back-to-back transfers produce continuous enables.
//   - Write to r0: the transfer is consumed (ready=1, rr_last updates) but ctrl_writeEnable=0 in
//     N+1.
//   - Same destination from A and B in one cycle: only the winner writes in N+1. The loser writes
//     in N+2, so the loser's data is final.
//   - Requesters must hold valid/reg/data stable until transferred. The arbiter holds no copy of
//     untransferred requests.
//   - Reset mid-operation: any registered write is dropped (enable forced 0) and the INIT sweep
//     restarts from r1.
//   - sweep_cnt is ADDR_W bits and never wraps in INIT; exit is at NUM_REGS-1.
// TESTING
//   1. Reset release, no requests
//      -> enable=1 for exactly 31 cycles with ctrl_writeReg 1..31 and data 0, then enable=0.
//      -> init_done rises the cycle after reg 31 is presented.
//   2. After init, A only: a_reg=5, a_data=32'hDEADBEEF
//      -> a_ready=1 the same cycle.
//      -> next cycle enable=1, writeReg=5, data=DEADBEEF; then enable=0.
//   3. A and B valid for 4 cycles: A r3/1, B r4/2, both held until transferred
//      -> grants A,B,A,B (first tie to A).
//      -> enable high on 4 consecutive cycles with matching reg/data.
//   4. A r7=11 and B r7=22 in the same cycle
//      -> A granted first, B next cycle.
//      -> writes r7=11 then r7=22; final r7=22.
//   5. B writes r0 with data 9
//      -> b_ready=1, next cycle enable=0.
//      -> the following A/B tie goes to A.
//   6. Reset asserted mid-RUN, one cycle after an A transfer
//      -> outputs clear immediately; the pending write is lost.
//      -> after release, the sweep restarts at r1 and ready stays 0 for 31 cycles.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Owns the single register-file write port: zero-fills r1..r(NUM_REGS-1) after reset,
// then shares the port round-robin between the ALU (A) and load/multicycle (B) writebacks.
module regfile_write_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clock,
    input  logic              ctrl_reset_n,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_reg,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_reg,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              ctrl_writeEnable,
    output logic [ADDR_W-1:0] ctrl_writeReg,
    output logic [DATA_W-1:0] data_writeReg,
    output logic              init_done
);

    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] ZERO_REG = '0;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } stateT;

    typedef enum logic {
        REQ_A,
        REQ_B
    } reqT;

    stateT             state;
    reqT               rrLast;
    logic [ADDR_W-1:0] sweepCnt;

    logic              aXfer_p0;
    logic              bXfer_p0;
    logic              vld_p0;
    logic [ADDR_W-1:0] grantReg_p0;
    logic [DATA_W-1:0] grantData_p0;

    // Stage p0: grant decision; on a tie the requester that did not win last goes first
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (state == ST_RUN) begin
            a_ready = a_valid && (!b_valid || (rrLast == REQ_B));
            b_ready = b_valid && (!a_valid || (rrLast == REQ_A));
        end
    end

    assign aXfer_p0     = a_valid & a_ready;
    assign bXfer_p0     = b_valid & b_ready;
    assign vld_p0       = aXfer_p0 | bXfer_p0;
    assign grantReg_p0  = aXfer_p0 ? a_reg  : b_reg;
    assign grantData_p0 = aXfer_p0 ? a_data : b_data;

    // Stage p1: registered write port
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            state            <= ST_INIT;
            sweepCnt         <= ADDR_W'(1);
            rrLast           <= REQ_B;
            ctrl_writeEnable <= 1'b0;
            ctrl_writeReg    <= '0;
            data_writeReg    <= '0;
            init_done        <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    ctrl_writeEnable <= 1'b1;
                    ctrl_writeReg    <= sweepCnt;
                    data_writeReg    <= '0;
                    if (sweepCnt == LAST_REG) begin
                        state <= ST_RUN;
                    end else begin
                        sweepCnt <= sweepCnt + ADDR_W'(1);
                    end
                end
                ST_RUN: begin
                    init_done <= 1'b1;
                    if (vld_p0) begin
                        rrLast <= aXfer_p0 ? REQ_A : REQ_B;
                    end
                    // A write aimed at r0 is consumed but never reaches the register file
                    if (vld_p0 && (grantReg_p0 != ZERO_REG)) begin
                        ctrl_writeEnable <= 1'b1;
                        ctrl_writeReg    <= grantReg_p0;
                        data_writeReg    <= grantData_p0;
                    end else begin
                        ctrl_writeEnable <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench: a rule-level grant model pushes expected writes; a monitor pops and
// compares them against the register-file write port.
module tb_regfile_write_arbiter;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    logic              clock = 1'b0;
    logic              ctrl_reset_n = 1'b0;
    logic              a_valid = 1'b0;
    logic [ADDR_W-1:0] a_reg = '0;
    logic [DATA_W-1:0] a_data = '0;
    logic              a_ready;
    logic              b_valid = 1'b0;
    logic [ADDR_W-1:0] b_reg = '0;
    logic [DATA_W-1:0] b_data = '0;
    logic              b_ready;
    logic              ctrl_writeEnable;
    logic [ADDR_W-1:0] ctrl_writeReg;
    logic [DATA_W-1:0] data_writeReg;
    logic              init_done;

    regfile_write_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)
    ) dut (
        .clock(clock), .ctrl_reset_n(ctrl_reset_n),
        .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
        .data_writeReg(data_writeReg), .init_done(init_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        int                cyc;
        logic [ADDR_W-1:0] rg;
        logic [DATA_W-1:0] data;
    } wrT;

    wrT                expQ[$];
    int                tests = 0;
    int                fails = 0;
    int                cyc = 0;
    int                modelRunAt = 1000000;
    bit                modelLastB = 1'b1;
    bit                aPend = 1'b0;
    bit                bPend = 1'b0;
    logic [ADDR_W-1:0] aR = '0;
    logic [ADDR_W-1:0] bR = '0;
    logic [DATA_W-1:0] aD = '0;
    logic [DATA_W-1:0] bD = '0;
    logic [DATA_W-1:0] modelRf[NUM_REGS];
    logic [DATA_W-1:0] dutRf[NUM_REGS];
    string             grants = "";

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: every enabled write must be the oldest expected one, in its expected cycle
    always @(negedge clock) begin : monitor
        wrT e;
        if (ctrl_reset_n) begin
            if (ctrl_writeEnable) begin
                if (expQ.size() > 0 && expQ[0].cyc == cyc) begin
                    e = expQ.pop_front();
                    check("write_reg", 64'(ctrl_writeReg), 64'(e.rg));
                    check("write_data", 64'(data_writeReg), 64'(e.data));
                    dutRf[ctrl_writeReg] = data_writeReg;
                end else begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got r%0d=%0h at cycle %0d, required no write",
                             ctrl_writeReg, data_writeReg, cyc);
                end
            end else if (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
                e = expQ.pop_front();
                tests++;
                fails++;
                $display("FAIL missing_write: got enable 0 at cycle %0d, required r%0d=%0h",
                         cyc, e.rg, e.data);
            end
        end
    end

    // Drive pending requests, predict grants from the arbitration rules, then advance one cycle
    task automatic tick();
        bit expA;
        bit expB;
        wrT w;
        a_valid = aPend; a_reg = aR; a_data = aD;
        b_valid = bPend; b_reg = bR; b_data = bD;
        #1;
        expA = 1'b0;
        expB = 1'b0;
        if (ctrl_reset_n && cyc >= modelRunAt) begin
            if (aPend && bPend) begin
                expA = modelLastB;
                expB = !modelLastB;
            end else begin
                expA = aPend;
                expB = bPend;
            end
        end
        check("a_ready", 64'(a_ready), 64'(expA));
        check("b_ready", 64'(b_ready), 64'(expB));
        if (a_ready) grants = {grants, "A"};
        else if (b_ready) grants = {grants, "B"};
        if (expA || expB) begin
            w.cyc  = cyc + 1;
            w.rg   = expA ? aR : bR;
            w.data = expA ? aD : bD;
            if (w.rg != 0) begin
                expQ.push_back(w);
                modelRf[w.rg] = w.data;
            end
            modelLastB = expB;
            if (expA) aPend = 1'b0;
            else bPend = 1'b0;
        end
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic releaseAndSweep(input bit holdValid);
        int relCyc;
        wrT w;
        expQ.delete();
        aPend = 1'b0;
        bPend = 1'b0;
        repeat (2) @(negedge clock);
        ctrl_reset_n = 1'b1;
        relCyc     = cyc;
        modelRunAt = relCyc + NUM_REGS - 1;
        modelLastB = 1'b1;
        for (int k = 0; k < NUM_REGS; k++) modelRf[k] = '0;
        for (int k = 1; k < NUM_REGS; k++) begin
            w.cyc = relCyc + k;
            w.rg = ADDR_W'(k);
            w.data = '0;
            expQ.push_back(w);
        end
        for (int k = 0; k < NUM_REGS - 1; k++) begin
            aPend = holdValid; aR = 5'd12; aD = 32'h1111;
            bPend = holdValid; bR = 5'd13; bD = 32'h2222;
            tick();
        end
        aPend = 1'b0;
        bPend = 1'b0;
        check("init_done_before", 64'(init_done), 64'd0);
        tick();
        check("init_done_after", 64'(init_done), 64'd1);
        tick();
        check("sweep_drained", 64'(expQ.size()), 64'd0);
    endtask

    task automatic randomPhase(input int n);
        for (int i = 0; i < n; i++) begin
            if (!aPend && $urandom_range(0, 99) < 60) begin
                aPend = 1'b1; aR = ADDR_W'($urandom_range(0, NUM_REGS - 1)); aD = $urandom;
            end
            if (!bPend && $urandom_range(0, 99) < 60) begin
                bPend = 1'b1; bR = ADDR_W'($urandom_range(0, NUM_REGS - 1)); bD = $urandom;
            end
            tick();
        end
        while (aPend || bPend) tick();
        idle(3);
        check("queue_empty", 64'(expQ.size()), 64'd0);
        for (int r = 1; r < NUM_REGS; r++) check($sformatf("rf_r%0d", r), 64'(dutRf[r]), 64'(modelRf[r]));
    endtask

    initial begin
        for (int k = 0; k < NUM_REGS; k++) dutRf[k] = 32'hBAD0_0000 | k;
        // Reset state, with requests present that must not be granted
        a_valid = 1'b1; b_valid = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_enable", 64'(ctrl_writeEnable), 64'd0);
        check("rst_reg", 64'(ctrl_writeReg), 64'd0);
        check("rst_data", 64'(data_writeReg), 64'd0);
        check("rst_init_done", 64'(init_done), 64'd0);
        check("rst_a_ready", 64'(a_ready), 64'd0);
        check("rst_b_ready", 64'(b_ready), 64'd0);
        a_valid = 1'b0; b_valid = 1'b0;

        releaseAndSweep(1'b0);

        // Tie sequence: both requesters keep asking
        grants = "";
        for (int i = 0; i < 4; i++) begin
            aPend = 1'b1; aR = 5'd3; aD = 32'd1;
            bPend = 1'b1; bR = 5'd4; bD = 32'd2;
            tick();
        end
        aPend = 1'b0; bPend = 1'b0;
        check("tie_order_ABAB", 64'(grants == "ABAB"), 64'd1);
        idle(2);

        // Same destination from both sides
        grants = "";
        aPend = 1'b1; aR = 5'd7; aD = 32'd11;
        bPend = 1'b1; bR = 5'd7; bD = 32'd22;
        while (aPend || bPend) tick();
        idle(2);
        check("same_dst_order_AB", 64'(grants == "AB"), 64'd1);
        check("same_dst_final_r7", 64'(dutRf[7]), 64'd22);

        // Write to r0 is consumed silently, and rr_last moves to B
        bPend = 1'b1; bR = 5'd0; bD = 32'd9;
        tick();
        grants = "";
        aPend = 1'b1; aR = 5'd1; aD = 32'hA1;
        bPend = 1'b1; bR = 5'd2; bD = 32'hB2;
        tick();
        check("tie_after_r0_goes_A", 64'(grants == "A"), 64'd1);
        while (aPend || bPend) tick();
        idle(2);

        // Single requester
        aPend = 1'b1; aR = 5'd5; aD = 32'hDEADBEEF;
        tick();
        idle(2);
        check("a_only_r5", 64'(dutRf[5]), 64'hDEADBEEF);

        randomPhase(300);

        // Reset one cycle after an A transfer: the registered write is lost
        aPend = 1'b1; aR = 5'd9; aD = 32'hCAFE;
        a_valid = 1'b1; a_reg = aR; a_data = aD; b_valid = 1'b0;
        #1;
        check("pre_reset_a_ready", 64'(a_ready), 64'd1);
        @(posedge clock);
        #1;
        ctrl_reset_n = 1'b0;
        expQ.delete();
        #1;
        check("midrst_enable", 64'(ctrl_writeEnable), 64'd0);
        check("midrst_reg", 64'(ctrl_writeReg), 64'd0);
        check("midrst_data", 64'(data_writeReg), 64'd0);
        check("midrst_init_done", 64'(init_done), 64'd0);
        @(negedge clock);
        releaseAndSweep(1'b1);

        randomPhase(60);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
